// File: rtl/lfsr_burst_ctrl_if.sv
// lfsr_burst_ctrl_if: control, backpressure and status bundle between the shell and the burst sequencer
interface lfsr_burst_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] burst_len;
  logic [GAP_W-1:0] gap;
  logic             sink_full;
  logic             gen_cmd;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] issued;
  modport master (
    output start, abort, burst_len, gap, sink_full,
    input  gen_cmd, busy, done, issued
  );
  modport slave (
    input  start, abort, burst_len, gap, sink_full,
    output gen_cmd, busy, done, issued
  );
endinterface

// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: issues a programmed number of gen_cmd pulses with a programmable idle gap
module lfsr_burst_ctrl #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  lfsr_burst_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t           state, state_d;
  logic [CNT_W-1:0] len_q, len_d, issued_d;
  logic [GAP_W-1:0] gap_q, gap_d, gap_cnt, gap_cnt_d;
  logic             gen_d, done_d;
  // State, captured burst settings and registered outputs; busy tracks the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      bus.gen_cmd <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.issued  <= '0;
    end else begin
      state       <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      gap_cnt     <= gap_cnt_d;
      bus.gen_cmd <= gen_d;
      bus.busy    <= state_d != IDLE;
      bus.done    <= done_d;
      bus.issued  <= issued_d;
    end
  end
  // Next state and next outputs; abort wins over everything, sink_full only stalls the decision cycle
  always_comb begin
    state_d   = state;
    len_d     = len_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt;
    issued_d  = bus.issued;
    gen_d     = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          len_d    = bus.burst_len;
          gap_d    = bus.gap;
          issued_d = '0;
          done_d   = bus.burst_len == '0;
          state_d  = done_d ? IDLE : ISSUE;
        end
      end
      ISSUE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.sink_full) begin
          gen_d    = 1'b1;
          issued_d = bus.issued + CNT_W'(1);
          if (issued_d == len_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q;
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt - GAP_W'(1);
          state_d   = gap_cnt == GAP_W'(1) ? ISSUE : GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// tb_lfsr_burst_ctrl: scoreboard bench; stimulus queues expected pulses, monitor pops and compares
module tb_lfsr_burst_ctrl;
  typedef struct {
    int          cyc;
    logic        gen;
    logic        done;
    logic        busy;
    logic [15:0] issued;
  } ev_t;
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lfsr_load = 1'b0;
  logic [15:0] lfsr = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          base;
  ev_t         exp_q[$];
  chk_t        chk_q[$];
  ev_t         e;
  chk_t        c;
  lfsr_burst_ctrl_if #(.CNT_W(16), .GAP_W(8)) bus ();
  lfsr_burst_ctrl #(.CNT_W(16), .GAP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  // cycle index used to place expected events
  always @(posedge clk) cyc <= cyc + 1;
  // off-chip pattern generator model: x^16+x^14+x^13+x^11+1, shifts once per gen_cmd cycle
  always @(posedge clk) begin
    if (lfsr_load) lfsr <= 16'hAAAA;
    else if (bus.gen_cmd) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  // monitor: every gen_cmd/done cycle pops one expected event; queued spot checks are compared too
  always @(negedge clk) begin
    if (rst_n && (bus.gen_cmd || bus.done)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d got gen=%b done=%b, required no event", cyc, bus.gen_cmd, bus.done);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.gen !== bus.gen_cmd || e.done !== bus.done || e.busy !== bus.busy || e.issued !== bus.issued) begin
          n_bad++;
          $display("FAIL pulse got cyc=%0d gen=%b done=%b busy=%b issued=%0d, required cyc=%0d gen=%b done=%b busy=%b issued=%0d",
                   cyc, bus.gen_cmd, bus.done, bus.busy, bus.issued, e.cyc, e.gen, e.done, e.busy, e.issued);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_cmp++;
      if (c.act !== c.exp) begin
        n_bad++;
        $display("FAIL %s got %0h, required %0h", c.name, c.act, c.exp);
      end
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_q.push_back('{name, act, exp});
  endtask
  task automatic push(input int cy, input logic g, input logic d, input logic b, input logic [15:0] i);
    exp_q.push_back('{cy, g, d, b, i});
  endtask
  task automatic burst_exp(input int b0, input int len, input int gp, input int stall, input int npulse);
    for (int k = 0; k < npulse; k++)
      push(b0 + 2 + stall + k * (gp + 1), 1'b1, k == len - 1, k != len - 1, 16'(k + 1));
  endtask
  task automatic go(input int len, input int gp);
    bus.burst_len = 16'(len);
    bus.gap       = 8'(gp);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask
  initial begin
    bus.start = 0; bus.abort = 0; bus.sink_full = 0; bus.burst_len = 0; bus.gap = 0;
    cycles(2);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_gen", 32'(bus.gen_cmd), 0);
    check("rst_issued", 32'(bus.issued), 0);
    rst_n = 1'b1;
    cycles(1);
    base = cyc; burst_exp(base, 4, 0, 0, 4); go(4, 0);
    check("b2b_busy_start", 32'(bus.busy), 1);
    cycles(4);
    check("b2b_busy_final", 32'(bus.busy), 0);
    cycles(3);
    check("b2b_issued", 32'(bus.issued), 4);
    check("b2b_leftover", exp_q.size(), 0);
    lfsr_load = 1'b1; cycles(1); lfsr_load = 1'b0;
    base = cyc; burst_exp(base, 3, 2, 0, 3); go(3, 2);
    cycles(10);
    check("gap_lfsr", 32'(lfsr), 32'h5550);
    check("gap_issued", 32'(bus.issued), 3);
    check("gap_leftover", exp_q.size(), 0);
    bus.sink_full = 1'b1;
    base = cyc; burst_exp(base, 2, 0, 9, 2); go(2, 0);
    cycles(9);
    bus.sink_full = 1'b0;
    cycles(5);
    check("bp_issued", 32'(bus.issued), 2);
    check("bp_leftover", exp_q.size(), 0);
    base = cyc; burst_exp(base, 10, 0, 0, 3); go(10, 0);
    cycles(3);
    bus.abort = 1'b1; cycles(1); bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    cycles(3);
    check("abort_issued", 32'(bus.issued), 3);
    check("abort_leftover", exp_q.size(), 0);
    base = cyc; push(base + 1, 1'b0, 1'b1, 1'b0, 16'd0); go(0, 0);
    check("zero_busy", 32'(bus.busy), 0);
    cycles(2);
    check("zero_leftover", exp_q.size(), 0);
    bus.abort = 1'b1; go(3, 0); bus.abort = 1'b0;
    check("abort_start_busy", 32'(bus.busy), 0);
    cycles(2);
    base = cyc; burst_exp(base, 5, 1, 0, 5); go(5, 1);
    cycles(2);
    bus.start = 1'b1; bus.burst_len = 16'd2; cycles(1); bus.start = 1'b0;
    cycles(1);
    bus.start = 1'b1; cycles(1); bus.start = 1'b0;
    cycles(8);
    check("ign_issued", 32'(bus.issued), 5);
    check("ign_leftover", exp_q.size(), 0);
    base = cyc; burst_exp(base, 5, 3, 0, 1); go(5, 3);
    cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_gen", 32'(bus.gen_cmd), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_issued", 32'(bus.issued), 0);
    @(negedge clk);
    check("arst_leftover", exp_q.size(), 0);
    rst_n = 1'b1;
    cycles(1);
    base = cyc; burst_exp(base, 1, 0, 0, 1); go(1, 0);
    cycles(3);
    check("post_issued", 32'(bus.issued), 1);
    check("post_leftover", exp_q.size(), 0);
    cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
